preg_ready_table: RTL and testbench
===================================

// Module: preg_ready_table
// PURPOSE
//   Responder side of ready_intf and producer side of wake_intf. Holds one ready bit per physical
//   register (ROB-indexed preg). Issue queries psrc1/psrc2 per dispatch slot and gets v1/v2 back.
//   Rename allocations clear bits; execute writebacks set bits and are rebroadcast as wakeups.
//   Sits between rename/issue and the ROB/execute writeback path.
// PARAMETERS
//   FETCH_WIDTH   2   dispatch slots: query ports and allocation ports
//   WB_WIDTH      2   writeback ports from execute; equals wakeup broadcast width
//   PREG_W        6   preg address width; table depth = 2**PREG_W
// PORTS
//   clk           in   1                        clock
//   reset         in   1                        async, active-high
//   alloc_valid   in   FETCH_WIDTH              rename allocates a destination preg
//   alloc_preg    in   FETCH_WIDTH*PREG_W       preg being allocated
//   wb_valid      in   WB_WIDTH                 execute result written this cycle
//   wb_preg       in   WB_WIDTH*PREG_W          preg written
//   branch_miss   in   1                        pipeline flush from ROB
//   psrc1,psrc2   in   FETCH_WIDTH*PREG_W       issue query addresses
//   v1,v2         out  FETCH_WIDTH              ready answer per query
//   wake_valid    out  WB_WIDTH                 wakeup broadcast valid
//   wake_preg     out  WB_WIDTH*PREG_W         wakeup broadcast preg
//   pending_cnt   out  PREG_W+1                 count of not-ready pregs
// BEHAVIOUR
//   - Reset (async, reset=1): all ready bits = 1; wake_valid = 0; wake_preg = 0; pending_cnt = 0.
//     Reset mid-operation drops all pending state immediately. The first rising edge after
//     deassertion is a normal update.
//   - Query path (combinational, 0 latency):
//     v1[i] = ready[psrc1[i]] OR any(wb_valid[k] && wb_preg[k]==psrc1[i]). v2 is computed the same way.
//     A same-cycle writeback is bypassed to the query. A same-cycle alloc is NOT visible to the
//     query: it returns the pre-alloc value. Rename resolves intra-group dependencies.
//   - Table update at the rising edge, in this priority (highest first):
//     1. branch_miss=1: every ready bit is set to 1. Allocs and writebacks in that cycle are ignored.
//     2. alloc_valid[i]: ready[alloc_preg[i]] <= 0.
//     3. wb_valid[k]: ready[wb_preg[k]] <= 1.
//     An alloc and a writeback to the same preg in the same cycle leave the bit cleared (alloc wins).
//     Duplicate writebacks to one preg are idempotent. Duplicate allocs to one preg clear it once.
//   - Wakeup: the wb ports are registered, giving 1-cycle latency.
//     wake_valid[k] <= wb_valid[k] & ~branch_miss, and wake_preg[k] <= wb_preg[k].
//     On branch_miss, wake_valid is 0 for the next cycle.
//     When wake_valid[k]=0, wake_preg[k] holds its last value.
//   - pending_cnt: registered. Equals the popcount of ~ready after the same edge's update, so it
//     tracks the table with 1-cycle latency. It is 0 after a flush. The maximum is 2**PREG_W,
//     hence the width PREG_W+1.
//   - No handshake or backpressure: every valid input is consumed in the cycle it is presented.
// TESTING
//   1. Reset -> v1=v2=all 1 for any psrc; wake_valid=0; pending_cnt=0.
//   2. Alloc preg 5 at cycle t -> querying psrc1=5 at t returns 1 (no alloc bypass);
//      at t+1 returns v1=0; pending_cnt=1 at t+1.
//   3. Preg 5 pending; wb_valid[0]=1, wb_preg=5 at t; query psrc2=5 at t -> v2=1 (bypass);
//      at t+1: wake_valid[0]=1, wake_preg[0]=5, pending_cnt=0.
//   4. Same cycle: alloc preg 9 on slot 0 and wb preg 9 on port 1 -> preg 9 not ready at t+1;
//      wake_valid[1]=1 with wake_preg[1]=9 is still emitted.
//   5. Alloc pregs 1..10 over 5 cycles, then branch_miss together with a wb of preg 3 ->
//      next cycle all v=1, pending_cnt=0, wake_valid=0.
//   6. Alloc pregs 0 and 63 (wrap ends); assert reset asynchronously mid-cycle ->
//      outputs return to reset values before the next edge.

Source files
------------

// File: rtl/preg_ready_table.sv
// Per-physical-register ready table. Answers the issue stage's source-ready queries,
// clears bits on rename allocation, sets them on writeback, and rebroadcasts writebacks as wakeups.
module preg_ready_table #(
    parameter int FETCH_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int PREG_W      = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FETCH_WIDTH-1:0]        alloc_valid,
    input  logic [FETCH_WIDTH*PREG_W-1:0] alloc_preg,
    input  logic [WB_WIDTH-1:0]           wb_valid,
    input  logic [WB_WIDTH*PREG_W-1:0]    wb_preg,
    input  logic                          branch_miss,
    input  logic [FETCH_WIDTH*PREG_W-1:0] psrc1,
    input  logic [FETCH_WIDTH*PREG_W-1:0] psrc2,
    output logic [FETCH_WIDTH-1:0]        v1,
    output logic [FETCH_WIDTH-1:0]        v2,
    output logic [WB_WIDTH-1:0]           wake_valid,
    output logic [WB_WIDTH*PREG_W-1:0]    wake_preg,
    output logic [PREG_W:0]               pending_cnt
);

    localparam int DEPTH = 1 << PREG_W;

    logic [DEPTH-1:0]             ready_q, ready_d;
    logic [PREG_W:0]              pending_q, pending_d;
    logic [WB_WIDTH-1:0]          wake_valid_q, wake_valid_d;
    logic [WB_WIDTH*PREG_W-1:0]   wake_preg_q, wake_preg_d;

    // Allocs are applied after writebacks so a same-cycle alloc/wb collision leaves the bit cleared.
    always_comb begin
        ready_d = ready_q;
        if (branch_miss) begin
            ready_d = '1;
        end else begin
            for (int k = 0; k < WB_WIDTH; k++) begin
                if (wb_valid[k]) begin
                    ready_d[wb_preg[k*PREG_W +: PREG_W]] = 1'b1;
                end
            end
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    ready_d[alloc_preg[i*PREG_W +: PREG_W]] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int p = 0; p < DEPTH; p++) begin
            pending_d = pending_d + {{PREG_W{1'b0}}, ~ready_d[p]};
        end
    end

    // A flushed writeback is not broadcast, and the preg field holds while the port is idle.
    always_comb begin
        wake_valid_d = '0;
        wake_preg_d  = wake_preg_q;
        for (int k = 0; k < WB_WIDTH; k++) begin
            if (wb_valid[k] && !branch_miss) begin
                wake_valid_d[k]                    = 1'b1;
                wake_preg_d[k*PREG_W +: PREG_W]    = wb_preg[k*PREG_W +: PREG_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q      <= '1;
            pending_q    <= '0;
            wake_valid_q <= '0;
            wake_preg_q  <= '0;
        end else begin
            ready_q      <= ready_d;
            pending_q    <= pending_d;
            wake_valid_q <= wake_valid_d;
            wake_preg_q  <= wake_preg_d;
        end
    end

    // Query ports see the pre-update table plus a same-cycle writeback bypass.
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_query
        logic [PREG_W-1:0] addr1, addr2;
        logic              byp1, byp2;

        assign addr1 = psrc1[gi*PREG_W +: PREG_W];
        assign addr2 = psrc2[gi*PREG_W +: PREG_W];

        always_comb begin
            byp1 = 1'b0;
            byp2 = 1'b0;
            for (int k = 0; k < WB_WIDTH; k++) begin
                if (wb_valid[k] && (wb_preg[k*PREG_W +: PREG_W] == addr1)) byp1 = 1'b1;
                if (wb_valid[k] && (wb_preg[k*PREG_W +: PREG_W] == addr2)) byp2 = 1'b1;
            end
        end

        assign v1[gi] = ready_q[addr1] | byp1;
        assign v2[gi] = ready_q[addr2] | byp2;
    end

    assign wake_valid  = wake_valid_q;
    assign wake_preg   = wake_preg_q;
    assign pending_cnt = pending_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Bench for preg_ready_table: directed vector table, randomized traffic against a
// per-preg reference model, and an asynchronous mid-cycle reset check.
module tb_preg_ready_table;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alloc_valid;
    logic [11:0] alloc_preg;
    logic [1:0]  wb_valid;
    logic [11:0] wb_preg;
    logic        branch_miss;
    logic [11:0] psrc1, psrc2;
    logic [1:0]  v1, v2;
    logic [1:0]  wake_valid;
    logic [11:0] wake_preg;
    logic [6:0]  pending_cnt;

    preg_ready_table #(.FETCH_WIDTH(2), .WB_WIDTH(2), .PREG_W(6)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .branch_miss(branch_miss),
        .psrc1(psrc1), .psrc2(psrc2),
        .v1(v1), .v2(v2),
        .wake_valid(wake_valid), .wake_preg(wake_preg),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one ready flag per preg, plus the last broadcast per wake port.
    bit         ready_m [64];
    bit         wake_v_m [2];
    logic [5:0] wake_p_m [2];

    typedef struct {
        logic [1:0]  av;
        logic [11:0] ap;
        logic [1:0]  wv;
        logic [11:0] wp;
        logic        bm;
        logic [11:0] s1;
        logic [11:0] s2;
        logic [1:0]  ev1;
        logic [1:0]  ev2;
        logic [1:0]  ewv;
        logic [11:0] ewp;
        logic [6:0]  epend;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [11:0] pk(input int s0, input int s1);
        logic [5:0] a, b;
        a = s0[5:0];
        b = s1[5:0];
        return {b, a};
    endfunction

    function automatic vec_t mk(input logic [1:0] av, input logic [11:0] ap,
                                input logic [1:0] wv, input logic [11:0] wp, input logic bm,
                                input logic [11:0] s1, input logic [11:0] s2,
                                input logic [1:0] ev1, input logic [1:0] ev2,
                                input logic [1:0] ewv, input logic [11:0] ewp,
                                input int epend);
        vec_t v;
        v.av = av; v.ap = ap; v.wv = wv; v.wp = wp; v.bm = bm;
        v.s1 = s1; v.s2 = s2; v.ev1 = ev1; v.ev2 = ev2; v.ewv = ewv; v.ewp = ewp;
        v.epend = epend[6:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pending();
        int c = 0;
        for (int p = 0; p < 64; p++) if (!ready_m[p]) c++;
        return c;
    endfunction

    function automatic logic [1:0] model_query(input logic [11:0] ps);
        logic [1:0] r;
        for (int i = 0; i < 2; i++) begin
            int a = int'(ps[i*6 +: 6]);
            r[i] = ready_m[a];
            for (int k = 0; k < 2; k++)
                if (wb_valid[k] && int'(wb_preg[k*6 +: 6]) == a) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 64; p++) ready_m[p] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wake_v_m[k] = 1'b0;
            wake_p_m[k] = '0;
        end
    endtask

    task automatic model_update();
        for (int p = 0; p < 64; p++) begin
            bit a = 0, w = 0;
            for (int i = 0; i < 2; i++) if (alloc_valid[i] && int'(alloc_preg[i*6 +: 6]) == p) a = 1;
            for (int k = 0; k < 2; k++) if (wb_valid[k] && int'(wb_preg[k*6 +: 6]) == p) w = 1;
            if (branch_miss) ready_m[p] = 1'b1;
            else if (a)      ready_m[p] = 1'b0;
            else if (w)      ready_m[p] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            wake_v_m[k] = wb_valid[k] && !branch_miss;
            if (wake_v_m[k]) wake_p_m[k] = wb_preg[k*6 +: 6];
        end
    endtask

    task automatic clear_inputs();
        alloc_valid = '0; alloc_preg = '0; wb_valid = '0; wb_preg = '0;
        branch_miss = 1'b0; psrc1 = '0; psrc2 = '0;
    endtask

    // One cycle: check queries before the edge, clock, then check registered outputs.
    task automatic step(input bit use_tbl, input int r);
        logic [1:0] e1, e2;
        #1;
        e1 = model_query(psrc1);
        e2 = model_query(psrc2);
        chk("v1_model", 64'(v1), 64'(e1));
        chk("v2_model", 64'(v2), 64'(e2));
        if (use_tbl) begin
            chk($sformatf("v1_row%0d", r), 64'(v1), 64'(tbl[r].ev1));
            chk($sformatf("v2_row%0d", r), 64'(v2), 64'(tbl[r].ev2));
        end
        @(posedge clk);
        model_update();
        #1;
        chk("wake_valid_model", 64'(wake_valid), 64'({wake_v_m[1], wake_v_m[0]}));
        chk("wake_preg_model", 64'(wake_preg), 64'({wake_p_m[1], wake_p_m[0]}));
        chk("pending_model", 64'(pending_cnt), 64'(model_pending()));
        if (use_tbl) begin
            chk($sformatf("wake_valid_row%0d", r), 64'(wake_valid), 64'(tbl[r].ewv));
            chk($sformatf("wake_preg_row%0d", r), 64'(wake_preg), 64'(tbl[r].ewp));
            chk($sformatf("pending_row%0d", r), 64'(pending_cnt), 64'(tbl[r].epend));
        end
    endtask

    function automatic logic [5:0] rp();
        if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 7));
        return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        //                av     ap          wv     wp          bm  s1           s2            ev1    ev2    ewv    ewp        pend
        tbl[0]  = mk(2'b01, pk(5,0),  2'b00, pk(0,0), 0, pk(5,0),  pk(0,0),   2'b11, 2'b11, 2'b00, pk(0,0), 1);
        tbl[1]  = mk(2'b00, pk(0,0),  2'b00, pk(0,0), 0, pk(5,0),  pk(0,0),   2'b10, 2'b11, 2'b00, pk(0,0), 1);
        tbl[2]  = mk(2'b00, pk(0,0),  2'b01, pk(5,0), 0, pk(5,0),  pk(5,0),   2'b11, 2'b11, 2'b01, pk(5,0), 0);
        tbl[3]  = mk(2'b01, pk(9,0),  2'b10, pk(0,9), 0, pk(9,0),  pk(0,0),   2'b11, 2'b11, 2'b10, pk(5,9), 1);
        tbl[4]  = mk(2'b00, pk(0,0),  2'b00, pk(0,0), 0, pk(9,0),  pk(0,0),   2'b10, 2'b11, 2'b00, pk(5,9), 1);
        tbl[5]  = mk(2'b11, pk(1,2),  2'b00, pk(0,0), 0, pk(0,0),  pk(0,0),   2'b11, 2'b11, 2'b00, pk(5,9), 3);
        tbl[6]  = mk(2'b11, pk(3,4),  2'b00, pk(0,0), 0, pk(1,2),  pk(0,0),   2'b00, 2'b11, 2'b00, pk(5,9), 5);
        tbl[7]  = mk(2'b11, pk(5,6),  2'b00, pk(0,0), 0, pk(0,0),  pk(0,0),   2'b11, 2'b11, 2'b00, pk(5,9), 7);
        tbl[8]  = mk(2'b11, pk(7,8),  2'b00, pk(0,0), 0, pk(0,0),  pk(0,0),   2'b11, 2'b11, 2'b00, pk(5,9), 9);
        tbl[9]  = mk(2'b11, pk(9,10), 2'b00, pk(0,0), 0, pk(0,0),  pk(9,10),  2'b11, 2'b10, 2'b00, pk(5,9), 10);
        tbl[10] = mk(2'b10, pk(0,20), 2'b01, pk(3,0), 1, pk(3,4),  pk(0,0),   2'b01, 2'b11, 2'b00, pk(5,9), 0);
        tbl[11] = mk(2'b00, pk(0,0),  2'b00, pk(0,0), 0, pk(3,4),  pk(10,20), 2'b11, 2'b11, 2'b00, pk(5,9), 0);
        tbl[12] = mk(2'b11, pk(7,7),  2'b00, pk(0,0), 0, pk(7,0),  pk(0,0),   2'b11, 2'b11, 2'b00, pk(5,9), 1);
        tbl[13] = mk(2'b00, pk(0,0),  2'b11, pk(7,7), 0, pk(7,0),  pk(0,0),   2'b11, 2'b11, 2'b11, pk(7,7), 0);

        // Reset state: every preg answers ready, no wakeups, nothing pending.
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            psrc1 = {rp(), rp()};
            psrc2 = {rp(), rp()};
            #1;
            chk("reset_v1", 64'(v1), 64'h3);
            chk("reset_v2", 64'(v2), 64'h3);
        end
        chk("reset_wake_valid", 64'(wake_valid), 64'h0);
        chk("reset_wake_preg", 64'(wake_preg), 64'h0);
        chk("reset_pending", 64'(pending_cnt), 64'h0);
        reset = 1'b0;

        // Directed vectors.
        for (int r = 0; r < 14; r++) begin
            alloc_valid = tbl[r].av; alloc_preg = tbl[r].ap;
            wb_valid    = tbl[r].wv; wb_preg    = tbl[r].wp;
            branch_miss = tbl[r].bm;
            psrc1       = tbl[r].s1; psrc2      = tbl[r].s2;
            step(1'b1, r);
            $display("row %0d: v1=%b v2=%b wake_valid=%b wake_preg=%h pending=%0d",
                     r, v1, v2, wake_valid, wake_preg, pending_cnt);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            alloc_valid = 2'($urandom);
            alloc_preg  = {rp(), rp()};
            wb_valid    = 2'($urandom);
            wb_preg     = {rp(), rp()};
            branch_miss = ($urandom_range(0, 31) == 0);
            psrc1       = {rp(), rp()};
            psrc2       = {rp(), rp()};
            step(1'b0, 0);
            if (n % 50 == 0)
                $display("rand %0d: pending=%0d wake_valid=%b", n, pending_cnt, wake_valid);
        end

        // Flush to a clean table, allocate both wrap ends, then reset asynchronously mid-cycle.
        clear_inputs();
        branch_miss = 1'b1;
        step(1'b0, 0);
        clear_inputs();
        alloc_valid = 2'b11;
        alloc_preg  = pk(0, 63);
        step(1'b0, 0);
        chk("wrap_pending", 64'(pending_cnt), 64'd2);
        clear_inputs();
        psrc1 = pk(0, 63);
        #1;
        chk("wrap_v1_before_reset", 64'(v1), 64'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_v1", 64'(v1), 64'h3);
        chk("async_reset_pending", 64'(pending_cnt), 64'h0);
        chk("async_reset_wake_valid", 64'(wake_valid), 64'h0);
        chk("async_reset_wake_preg", 64'(wake_preg), 64'h0);
        $display("async reset: v1=%b pending=%0d", v1, pending_cnt);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        alloc_valid = 2'b01;
        alloc_preg  = pk(63, 0);
        step(1'b0, 0);
        chk("post_reset_pending", 64'(pending_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
